// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer: fetch/execute T-state counter with opcode decode.
// Drives one-hot bus-driver selects, register load strobes, PC and ALU controls.
module sap1_control_sequencer #(
    parameter int unsigned OPCODE_WIDTH = 4,
    parameter int unsigned NUM_STEPS    = 5
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    input  logic                    i_carry,
    input  logic                    i_zero,
    output logic                    o_a_reg_out,
    output logic                    o_b_reg_out,
    output logic                    o_alu_out,
    output logic                    o_ram_out,
    output logic                    o_instruction_reg_out,
    output logic                    o_program_counter_out,
    output logic                    o_a_reg_in,
    output logic                    o_b_reg_in,
    output logic                    o_mar_in,
    output logic                    o_ram_in,
    output logic                    o_instruction_reg_in,
    output logic                    o_out_reg_in,
    output logic                    o_pc_inc,
    output logic                    o_pc_load,
    output logic                    o_alu_sub,
    output logic [2:0]              o_step,
    output logic                    o_halted
);

    localparam logic [2:0] LastStep = 3'(NUM_STEPS - 1);

    localparam logic [3:0] OpLda = 4'h1;
    localparam logic [3:0] OpAdd = 4'h2;
    localparam logic [3:0] OpSub = 4'h3;
    localparam logic [3:0] OpSta = 4'h4;
    localparam logic [3:0] OpLdi = 4'h5;
    localparam logic [3:0] OpJmp = 4'h6;
    localparam logic [3:0] OpJc  = 4'h7;
    localparam logic [3:0] OpJz  = 4'h8;
    localparam logic [3:0] OpOut = 4'hE;
    localparam logic [3:0] OpHlt = 4'hF;

    logic [2:0] step_q, step_d;
    logic       halted_q, halted_d;
    logic [3:0] opcode;
    logic       run;

    assign opcode = 4'(i_opcode);

    // Reset is folded in so outputs drop the instant reset rises, not at the next edge.
    assign run = i_enable & ~halted_q & ~i_reset;

    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (i_enable && !halted_q) begin
            if (step_q == 3'd2 && opcode == OpHlt) begin
                halted_d = 1'b1;
                step_d   = 3'd0;
            end else if (step_q == LastStep) begin
                step_d = 3'd0;
            end else begin
                step_d = step_q + 3'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            step_q   <= 3'd0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        o_a_reg_out           = 1'b0;
        o_b_reg_out           = 1'b0;
        o_alu_out             = 1'b0;
        o_ram_out             = 1'b0;
        o_instruction_reg_out = 1'b0;
        o_program_counter_out = 1'b0;
        o_a_reg_in            = 1'b0;
        o_b_reg_in            = 1'b0;
        o_mar_in              = 1'b0;
        o_ram_in              = 1'b0;
        o_instruction_reg_in  = 1'b0;
        o_out_reg_in          = 1'b0;
        o_pc_inc              = 1'b0;
        o_pc_load             = 1'b0;
        o_alu_sub             = 1'b0;
        if (run) begin
            case (step_q)
                3'd0: begin
                    o_program_counter_out = 1'b1;
                    o_mar_in              = 1'b1;
                end
                3'd1: begin
                    o_ram_out            = 1'b1;
                    o_instruction_reg_in = 1'b1;
                    o_pc_inc             = 1'b1;
                end
                3'd2: begin
                    case (opcode)
                        OpLda, OpAdd, OpSub, OpSta: begin
                            o_instruction_reg_out = 1'b1;
                            o_mar_in              = 1'b1;
                        end
                        OpLdi: begin
                            o_instruction_reg_out = 1'b1;
                            o_a_reg_in            = 1'b1;
                        end
                        OpJmp: begin
                            o_instruction_reg_out = 1'b1;
                            o_pc_load             = 1'b1;
                        end
                        OpJc: begin
                            o_instruction_reg_out = i_carry;
                            o_pc_load             = i_carry;
                        end
                        OpJz: begin
                            o_instruction_reg_out = i_zero;
                            o_pc_load             = i_zero;
                        end
                        OpOut: begin
                            o_a_reg_out  = 1'b1;
                            o_out_reg_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd3: begin
                    case (opcode)
                        OpLda: begin
                            o_ram_out  = 1'b1;
                            o_a_reg_in = 1'b1;
                        end
                        OpAdd, OpSub: begin
                            o_ram_out  = 1'b1;
                            o_b_reg_in = 1'b1;
                        end
                        OpSta: begin
                            o_a_reg_out = 1'b1;
                            o_ram_in    = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd4: begin
                    if (opcode == OpAdd || opcode == OpSub) begin
                        o_alu_out  = 1'b1;
                        o_a_reg_in = 1'b1;
                        o_alu_sub  = (opcode == OpSub);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_step   = step_q;
    assign o_halted = halted_q;

endmodule
